// File: rtl/mac_cs_accumulator.sv
// Carry-save accumulator for the MAC compressor tree output.
// Beats are accumulated redundantly, then resolved to binary one CHUNK slice per cycle.
module mac_cs_accumulator #(
    parameter int W     = 16,
    parameter int ACC_W = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic [15:0]      count
);
    // state   | meaning
    // ACCUM   | accepting beats into the carry-save accumulator
    // RESOLVE | chunked carry-propagate add, LSB slice first
    // HOLD    | result presented, waiting for res_ready
    localparam int N     = ACC_W / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_s_q, acc_s_d;
    // Carry vector has implied weight 2^(i+1); its top bit would land at 2^ACC_W, so it is not stored.
    logic [ACC_W-2:0]   acc_c_q, acc_c_d;
    logic               cc_q, cc_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [15:0]        count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               res_valid_q, res_valid_d;

    logic [ACC_W-1:0]   op_s, op_c, acc_c_sh, s1, c1_sh, cs_sum;
    logic [ACC_W-2:0]   c1_lo, cs_carry;
    logic [CNT_W-1:0]   slice_idx;
    logic [31:0]        slice_base;
    logic [CHUNK-1:0]   slice_a, slice_b;
    logic [CHUNK:0]     slice_sum;
    logic               accept, handshake;

    // One row of 4:2 compressors: two chained full-adder layers, no ripple.
    assign op_s     = ACC_W'(in_sum);
    assign op_c     = ACC_W'(in_carry) << 1;
    assign acc_c_sh = {acc_c_q, 1'b0};
    assign s1       = acc_s_q ^ acc_c_sh ^ op_s;
    assign c1_lo    = (acc_s_q[ACC_W-2:0] & acc_c_sh[ACC_W-2:0])
                    | (acc_s_q[ACC_W-2:0] & op_s[ACC_W-2:0])
                    | (acc_c_sh[ACC_W-2:0] & op_s[ACC_W-2:0]);
    assign c1_sh    = {c1_lo, 1'b0};
    assign cs_sum   = s1 ^ op_c ^ c1_sh;
    assign cs_carry = (s1[ACC_W-2:0] & op_c[ACC_W-2:0])
                    | (s1[ACC_W-2:0] & c1_sh[ACC_W-2:0])
                    | (op_c[ACC_W-2:0] & c1_sh[ACC_W-2:0]);

    assign slice_idx  = CNT_W'(N - 1) - rcnt_q;
    assign slice_base = 32'(slice_idx) * 32'(CHUNK);
    assign slice_a    = acc_s_q[slice_base +: CHUNK];
    assign slice_b    = acc_c_sh[slice_base +: CHUNK];
    assign slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, cc_q};

    assign accept    = in_valid & in_ready_q;
    assign handshake = res_valid_q & res_ready;

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        cc_d        = cc_q;
        rcnt_d      = rcnt_q;
        result_d    = result_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        res_valid_d = res_valid_q;
        case (state_q)
            ACCUM: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    acc_s_d = cs_sum;
                    acc_c_d = cs_carry;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (in_last) begin
                        state_d    = RESOLVE;
                        in_ready_d = 1'b0;
                        rcnt_d     = CNT_W'(N - 1);
                        cc_d       = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                result_d[slice_base +: CHUNK] = slice_sum[CHUNK-1:0];
                cc_d = slice_sum[CHUNK];
                if (rcnt_q == '0) begin
                    state_d     = HOLD;
                    res_valid_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_d     = ACCUM;
                    acc_s_d     = '0;
                    acc_c_d     = '0;
                    cc_d        = 1'b0;
                    count_d     = '0;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cc_q        <= 1'b0;
            rcnt_q      <= '0;
            result_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            cc_q        <= cc_d;
            rcnt_q      <= rcnt_d;
            result_q    <= result_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign count     = count_q;
endmodule

// File: tb/tb_mac_cs_accumulator.sv
// Self-checking bench for mac_cs_accumulator: vector table, corner sequences,
// a narrow wrap instance and randomized groups against an arithmetic model.
module tb_mac_cs_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_last, res_valid, res_ready;
    logic [15:0] in_sum, in_carry, count;
    logic [31:0] result;

    logic        w_in_valid, w_in_ready, w_in_last, w_res_valid, w_res_ready;
    logic [15:0] w_in_sum, w_in_carry, w_count;
    logic [19:0] w_result;

    mac_cs_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .count(count)
    );

    mac_cs_accumulator #(.W(16), .ACC_W(20), .CHUNK(5)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_sum(w_in_sum), .in_carry(w_in_carry), .in_last(w_in_last),
        .res_valid(w_res_valid), .res_ready(w_res_ready), .result(w_result), .count(w_count)
    );

    typedef struct {
        logic [15:0] s;
        logic [15:0] c;
        logic        last;
        logic [31:0] exp_res;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 10;
    vec_t tv [NV];

    int          checks = 0;
    int          errors = 0;
    int          stall, k, nb, gap;
    logic        seen;
    logic [15:0] rs, rc;
    logic [31:0] tot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after an edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input logic last,
                             output int stl);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        stl      = 0;
        while (!in_ready && stl < 50) begin
            @(posedge clk); #1;
            stl++;
        end
        chk("beat_accept_timeout", 32'(stl >= 50), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the edge that accepted the last beat (edge 0).
    task automatic wait_result(input logic [31:0] exp_res, input logic [15:0] exp_cnt,
                               input int hold_cycles);
        int lat;
        lat = 0;
        chk("ready_low_after_last", 32'(in_ready), 32'd0);
        while (!res_valid && lat < 20) begin
            res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        res_ready = 1'b0;
        chk("latency", lat, 32'd4);
        chk("result", result, exp_res);
        chk("count", 32'(count), 32'(exp_cnt));
        in_valid = 1'b1;
        in_sum   = 16'($urandom);
        in_carry = 16'($urandom);
        in_last  = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_result", result, exp_res);
            chk("hold_count", 32'(count), 32'(exp_cnt));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("valid_after_hs", 32'(res_valid), 32'd0);
        chk("ready_after_hs", 32'(in_ready), 32'd1);
        chk("count_after_hs", 32'(count), 32'd0);
    endtask

    initial begin
        in_valid = 0; in_last = 0; in_sum = 0; in_carry = 0; res_ready = 0;
        w_in_valid = 0; w_in_last = 0; w_in_sum = 0; w_in_carry = 0; w_res_ready = 0;

        tv[0] = '{16'h0005, 16'h0003, 1'b1, 32'h0000000B, 16'd1};
        tv[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'h0,        16'd0};
        tv[2] = '{16'h0001, 16'h0000, 1'b0, 32'h0,        16'd0};
        tv[3] = '{16'h1234, 16'h0010, 1'b1, 32'h00031252, 16'd3};
        tv[4] = '{16'h0000, 16'h0000, 1'b1, 32'h00000000, 16'd1};
        tv[5] = '{16'hFFFF, 16'h0000, 1'b1, 32'h0000FFFF, 16'd1};
        tv[6] = '{16'h0000, 16'hFFFF, 1'b1, 32'h0001FFFE, 16'd1};
        tv[7] = '{16'h8000, 16'h8000, 1'b0, 32'h0,        16'd0};
        tv[8] = '{16'h8000, 16'h8000, 1'b0, 32'h0,        16'd0};
        tv[9] = '{16'h00FF, 16'h0080, 1'b1, 32'h000301FF, 16'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_w_in_ready", 32'(w_in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            send_beat(tv[i].s, tv[i].c, tv[i].last, stall);
            chk($sformatf("tv%0d_stall", i), stall, 32'd0);
            if (tv[i].last) wait_result(tv[i].exp_res, tv[i].exp_cnt, 0);
        end

        // Backpressure in HOLD with in_valid asserted, then a fresh one-beat group.
        send_beat(16'h0010, 16'h0020, 1'b1, stall);
        wait_result(32'h00000050, 16'd1, 5);
        send_beat(16'h0001, 16'h0000, 1'b1, stall);
        chk("bp_next_stall", stall, 32'd0);
        wait_result(32'h00000001, 16'd1, 0);

        // Reset during the second resolve cycle aborts the group.
        send_beat(16'h0007, 16'h0007, 1'b1, stall);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        send_beat(16'h0002, 16'h0001, 1'b1, stall);
        wait_result(32'h00000004, 16'd1, 0);

        // Reset during HOLD also aborts.
        send_beat(16'h0003, 16'h0000, 1'b1, stall);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_before_rst", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("hold_rst_valid", 32'(res_valid), 32'd0);
        chk("hold_rst_count", 32'(count), 32'd0);

        // Wrap on the 20-bit instance: 6 * 0x2FFFD mod 2^20.
        @(posedge clk); #1;
        w_in_valid = 1'b1;
        w_in_sum   = 16'hFFFF;
        w_in_carry = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            w_in_last = (i == 5);
            chk("wrap_ready", 32'(w_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        w_in_last  = 1'b0;
        k = 0;
        while (!w_res_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wrap_latency", k, 32'd4);
        chk("wrap_result", 32'(w_result), 32'h0001FFEE);
        chk("wrap_count", 32'(w_count), 32'd6);
        w_res_ready = 1'b1;
        @(posedge clk); #1;
        w_res_ready = 1'b0;
        chk("wrap_valid_after_hs", 32'(w_res_valid), 32'd0);

        // Randomized groups checked against a plain-arithmetic model.
        for (int g = 0; g < 30; g++) begin
            nb  = $urandom_range(1, 6);
            tot = 32'd0;
            for (int b = 0; b < nb; b++) begin
                rs  = 16'($urandom);
                rc  = 16'($urandom);
                tot = tot + 32'(rs) + (32'(rc) << 1);
                gap = $urandom_range(0, 2);
                for (int j = 0; j < gap; j++) begin
                    @(posedge clk); #1;
                end
                send_beat(rs, rc, (b == nb - 1), stall);
            end
            wait_result(tot, 16'(nb), $urandom_range(0, 3));
        end

        // Count saturation: 65537 back-to-back beats of value 1.
        in_valid = 1'b1;
        in_sum   = 16'h0001;
        in_carry = 16'h0000;
        for (int i = 0; i < 65537; i++) begin
            in_last = (i == 65536);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result(32'h00010001, 16'hFFFF, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
